// File: rtl/regfile_write_arbiter_if.sv
// Request-side bundle for the register-file write arbiter.
// Three requesters share one bundle. Slot i carries valid[i], addr[i*ADDR_W +: ADDR_W]
// and data[i*DATA_W +: DATA_W].
//   master : requesters, which drive valid/addr/data and sample ready
//   slave  : arbiter, which samples valid/addr/data and drives ready (combinational)
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [2:0]          req_valid;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's two write ports among three requesters
// (0 = writeback, 1 = accelerator, 2 = load-return).
// Ordering: starving requesters come first, then round-robin order.
// Two requests to the same register are never granted in one cycle.
// x0 requests are acknowledged at once and use no port.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req (slave)                       valid/addr/data in, combinational ready out
//   RegWrite/Write_register/Write_data     registered write port 1
//   RegWrite2/Write_register2/Write_data2  registered write port 2
//   starve_flag                       registered, bit i set while requester i is starving
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_write_arbiter_if.slave req,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     Write_register,
  output logic [DATA_W-1:0]     Write_data,
  output logic                  RegWrite2,
  output logic [ADDR_W-1:0]     Write_register2,
  output logic [DATA_W-1:0]     Write_data2,
  output logic [2:0]            starve_flag
);

  localparam int unsigned NREQ  = 3;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        rr_ptr;
  logic [CNT_W-1:0]  wait_cnt [NREQ];
  logic [CNT_W-1:0]  wait_nxt [NREQ];
  logic [NREQ-1:0]   starve_nxt;

  logic [ADDR_W-1:0] addr [NREQ];
  logic [DATA_W-1:0] data [NREQ];
  logic [NREQ-1:0]   live;
  logic [NREQ-1:0]   x0_req;
  logic [NREQ-1:0]   starving;

  logic [NREQ-1:0]   grant;
  logic              g1_v;
  logic              g2_v;
  logic [1:0]        g1_idx;
  logic [1:0]        g2_idx;
  logic [1:0]        last_idx;

  // Unpack the per-requester slots and classify each request.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr[i]     = req.req_addr[i*ADDR_W +: ADDR_W];
      data[i]     = req.req_data[i*DATA_W +: DATA_W];
      live[i]     = req.req_valid[i] && (addr[i] != '0);
      x0_req[i]   = req.req_valid[i] && (addr[i] == '0);
      starving[i] = (wait_cnt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Grant walk. Pass 0 visits starving requesters in ascending index.
  // Pass 1 visits the rest in round-robin order starting at rr_ptr.
  // A port-2 candidate that hits port 1's register is skipped.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    grant    = '0;
    g1_v     = 1'b0;
    g2_v     = 1'b0;
    g1_idx   = '0;
    g2_idx   = '0;
    last_idx = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (pass == 0) ? 2'(k) : 2'((int'(rr_ptr) + k) % NREQ);
        if (live[idx] && (starving[idx] == (pass == 0)) && !g2_v) begin
          if (!g1_v) begin
            g1_v        = 1'b1;
            g1_idx      = idx;
            grant[idx]  = 1'b1;
            last_idx    = idx;
          end else if (addr[idx] != addr[g1_idx]) begin
            g2_v        = 1'b1;
            g2_idx      = idx;
            grant[idx]  = 1'b1;
            last_idx    = idx;
          end
        end
      end
    end
  end

  // Ready covers port grants and x0 acknowledgements. It is held low during reset.
  always_comb begin
    req.req_ready = reset ? '0 : (x0_req | grant);
  end

  // Wait counters. They count while a nonzero request is refused and saturate at the limit.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wait_nxt[i] = '0;
      if (live[i] && !grant[i]) begin
        wait_nxt[i] = starving[i] ? wait_cnt[i] : wait_cnt[i] + CNT_W'(1);
      end
      starve_nxt[i] = (wait_nxt[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Port registers, pointer and starvation state.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite        <= 1'b0;
      Write_register  <= '0;
      Write_data      <= '0;
      RegWrite2       <= 1'b0;
      Write_register2 <= '0;
      Write_data2     <= '0;
      rr_ptr          <= '0;
      starve_flag     <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      RegWrite        <= g1_v;
      Write_register  <= g1_v ? addr[g1_idx] : '0;
      Write_data      <= g1_v ? data[g1_idx] : '0;
      RegWrite2       <= g2_v;
      Write_register2 <= g2_v ? addr[g2_idx] : '0;
      Write_data2     <= g2_v ? data[g2_idx] : '0;
      if (g1_v) begin
        rr_ptr <= (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
      end
      starve_flag <= starve_nxt;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= wait_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter. It runs directed vectors with literal expectations,
// plus a queue-based reference model that is checked on every negedge.
module tb_regfile_write_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          RegWrite, RegWrite2;
  logic [AW-1:0] Write_register, Write_register2;
  logic [DW-1:0] Write_data, Write_data2;
  logic [2:0]    starve_flag;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .req(bus),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .RegWrite2(RegWrite2), .Write_register2(Write_register2), .Write_data2(Write_data2),
    .starve_flag(starve_flag)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int            m_ptr = 0;
  int            m_wait [3] = '{0, 0, 0};
  logic          m_p1v = 1'b0, m_p2v = 1'b0;
  logic [AW-1:0] m_p1a = '0, m_p2a = '0;
  logic [DW-1:0] m_p1d = '0, m_p2d = '0;
  logic [DW-1:0] m_rf [2**AW];
  logic [DW-1:0] d_rf [2**AW];

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [AW-1:0] a_of(input int i);
    return bus.req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(input int i);
    return bus.req_data[i*DW +: DW];
  endfunction

  function automatic bit live(input int i);
    return bus.req_valid[i] && (a_of(i) != '0);
  endfunction

  // Builds the ordered candidate list from the rules, then takes up to two grants.
  function automatic void model_eval(output logic [2:0] rdy, output logic g1v, output int g1i,
                                     output logic g2v, output int g2i, output int last);
    int cand[$];
    rdy = '0; g1v = 1'b0; g2v = 1'b0; g1i = 0; g2i = 0; last = -1;
    if (reset) return;
    for (int i = 0; i < 3; i++) if (bus.req_valid[i] && a_of(i) == '0) rdy[i] = 1'b1;
    for (int i = 0; i < 3; i++) if (live(i) && m_wait[i] >= LIM) cand.push_back(i);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (live(i) && m_wait[i] < LIM) cand.push_back(i);
    end
    foreach (cand[j]) begin
      int i;
      i = cand[j];
      if (!g1v) begin
        g1v = 1'b1; g1i = i; rdy[i] = 1'b1; last = i;
      end else if (!g2v && a_of(i) != a_of(g1i)) begin
        g2v = 1'b1; g2i = i; rdy[i] = 1'b1; last = i;
      end
    end
  endfunction

  // Advance the model and both register files on each edge. A register file in reset ignores writes.
  always @(posedge clk) begin
    logic [2:0] rdy;
    logic g1v, g2v;
    int g1i, g2i, last;
    model_eval(rdy, g1v, g1i, g2v, g2i, last);
    if (!reset) begin
      if (m_p1v) m_rf[m_p1a] = m_p1d;
      if (m_p2v) m_rf[m_p2a] = m_p2d;
      if (RegWrite === 1'b1) d_rf[Write_register] = Write_data;
      if (RegWrite2 === 1'b1) d_rf[Write_register2] = Write_data2;
    end
    if (reset) begin
      m_ptr = 0;
      m_p1v = 1'b0; m_p1a = '0; m_p1d = '0;
      m_p2v = 1'b0; m_p2a = '0; m_p2d = '0;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
    end else begin
      m_p1v = g1v; m_p1a = g1v ? a_of(g1i) : '0; m_p1d = g1v ? d_of(g1i) : '0;
      m_p2v = g2v; m_p2a = g2v ? a_of(g2i) : '0; m_p2d = g2v ? d_of(g2i) : '0;
      if (last >= 0) m_ptr = (last + 1) % 3;
      for (int i = 0; i < 3; i++) begin
        if (live(i) && !rdy[i]) m_wait[i] = (m_wait[i] < LIM) ? m_wait[i] + 1 : LIM;
        else m_wait[i] = 0;
      end
    end
  end

  // Compare the DUT against the model on every negedge.
  always @(negedge clk) begin
    logic [2:0] rdy, mflag;
    logic g1v, g2v;
    int g1i, g2i, last;
    if (chk_en) begin
      model_eval(rdy, g1v, g1i, g2v, g2i, last);
      for (int i = 0; i < 3; i++) mflag[i] = (m_wait[i] == LIM);
      check("model_req_ready", 64'(bus.req_ready), 64'(rdy));
      check("model_port1", 64'({RegWrite, Write_register, Write_data}), 64'({m_p1v, m_p1a, m_p1d}));
      check("model_port2", 64'({RegWrite2, Write_register2, Write_data2}), 64'({m_p2v, m_p2a, m_p2d}));
      check("model_starve_flag", 64'(starve_flag), 64'(mflag));
    end
  end

  task automatic set_req(input logic [2:0] v, input logic [AW-1:0] a0, a1, a2,
                         input logic [DW-1:0] d0, d1, d2);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    next_cycle();
    chk_en = 1'b1;
    @(negedge clk);
    check("ready_held_in_reset", 64'(bus.req_ready), 64'h0);
    next_cycle();
    reset = 1'b0;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("post_reset_port1", 64'({RegWrite, Write_register, Write_data}), 64'h0);
    check("post_reset_port2", 64'({RegWrite2, Write_register2, Write_data2}), 64'h0);
    check("post_reset_starve", 64'(starve_flag), 64'h0);
    next_cycle();

    // Round-robin with three distinct addresses.
    set_req(3'b111, 5'd3, 5'd7, 5'd9, 32'h33, 32'h77, 32'h99);
    @(negedge clk);
    check("rr_c0_ready", 64'(bus.req_ready), 64'h3);
    next_cycle();
    set_req(3'b100, 5'd3, 5'd7, 5'd9, 32'h33, 32'h77, 32'h99);
    @(negedge clk);
    check("rr_c1_ready", 64'(bus.req_ready), 64'h4);
    check("rr_c1_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd3, 32'h33}));
    check("rr_c1_port2", 64'({RegWrite2, Write_register2, Write_data2}), 64'({1'b1, 5'd7, 32'h77}));
    next_cycle();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rr_c2_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd9, 32'h99}));
    check("rr_c2_port2_idle", 64'(RegWrite2), 64'h0);
    next_cycle();

    // Starvation: all three requesters target x8 and req2 loses twice.
    set_req(3'b111, 5'd8, 5'd8, 5'd8, 32'h80, 32'h81, 32'h82);
    @(negedge clk);
    check("starve_c0_ready", 64'(bus.req_ready), 64'h1);
    next_cycle();
    @(negedge clk);
    check("starve_c1_ready", 64'(bus.req_ready), 64'h2);
    check("starve_c1_flag", 64'(starve_flag), 64'h0);
    next_cycle();
    @(negedge clk);
    check("starve_c2_flag", 64'(starve_flag), 64'h4);
    check("starve_c2_ready", 64'(bus.req_ready), 64'h4);
    next_cycle();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("starve_c3_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd8, 32'h82}));
    next_cycle();

    // Same-address conflict on x5.
    set_req(3'b011, 5'd5, 5'd5, 5'd0, 32'hA, 32'hB, 32'h0);
    @(negedge clk);
    check("conf_c0_ready", 64'(bus.req_ready), 64'h1);
    next_cycle();
    set_req(3'b010, 5'd5, 5'd5, 5'd0, 32'hA, 32'hB, 32'h0);
    @(negedge clk);
    check("conf_c1_ready", 64'(bus.req_ready), 64'h2);
    check("conf_c1_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd5, 32'hA}));
    check("conf_c1_port2_idle", 64'(RegWrite2), 64'h0);
    next_cycle();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("conf_c2_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd5, 32'hB}));
    next_cycle();
    @(negedge clk);
    check("conf_x5_final", 64'(d_rf[5]), 64'hB);
    next_cycle();

    // x0 filter. The pointer sits at 2 here, so req2 takes port 1.
    set_req(3'b111, 5'd4, 5'd0, 5'd6, 32'h44, 32'h55, 32'h66);
    @(negedge clk);
    check("x0_ready", 64'(bus.req_ready), 64'h7);
    next_cycle();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("x0_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd6, 32'h66}));
    check("x0_port2", 64'({RegWrite2, Write_register2, Write_data2}), 64'({1'b1, 5'd4, 32'h44}));
    next_cycle();

    // Reset while a grant to x10 sits in the port registers.
    set_req(3'b001, 5'd10, 5'd0, 5'd0, 32'h10A, 32'h0, 32'h0);
    @(negedge clk);
    check("mid_c0_ready", 64'(bus.req_ready), 64'h1);
    next_cycle();
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_c1_port1", 64'({RegWrite, Write_register, Write_data}), 64'({1'b1, 5'd10, 32'h10A}));
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_c2_regwrite", 64'(RegWrite), 64'h0);
    check("mid_x10_unwritten", 64'(d_rf[10]), 64'h0);
    next_cycle();
    next_cycle();

    // Final register-file contents.
    check("rf_x3", 64'(d_rf[3]), 64'h33);
    check("rf_x7", 64'(d_rf[7]), 64'h77);
    check("rf_x9", 64'(d_rf[9]), 64'h99);
    check("rf_x8", 64'(d_rf[8]), 64'h82);
    check("rf_x4", 64'(d_rf[4]), 64'h44);
    check("rf_x6", 64'(d_rf[6]), 64'h66);
    for (int i = 0; i < 2**AW; i++) check($sformatf("rf_model_x%0d", i), 64'(d_rf[i]), 64'(m_rf[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's two write ports among three write requesters: core writeback, accelerator result, and load-return. Each cycle it grants up to two requests with fair round-robin order and starvation protection. It never drives both ports at the same nonzero register. Grants are registered, so the write ports (`RegWrite`/`Write_register`/`Write_data` and `RegWrite2`/`Write_register2`/`Write_data2`) are driven from flops one cycle after the handshake.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width
- `STARVE_LIMIT`, 4, wait cycles after which a requester is forced to top priority (≥1)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high; one clock, sampled on posedge
- `req_valid`  in  3  per-requester valid; bit0 = writeback, bit1 = accelerator, bit2 = load-return
- `req_addr`  in  3*ADDR_W  destination register per requester; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  3*DATA_W  write data per requester, same packing
- `req_ready`  out  3  combinational grant; handshake completes when valid & ready at posedge
- `RegWrite`, `Write_register`, `Write_data`  out  1/ADDR_W/DATA_W  register-file write port 1
- `RegWrite2`, `Write_register2`, `Write_data2`  out  1/ADDR_W/DATA_W  register-file write port 2
- `starve_flag`  out  3  registered; bit i high while requester i is starving

## Operation
- **Requester stability:** a requester holds `req_addr`/`req_data` stable while `req_valid` is high and `req_ready` is low.
- **x0 requests:** a valid request with `req_addr == 0` gets `req_ready = 1` in the same cycle. It consumes no port, does not count toward the two-grant limit, and does not move the pointer.
- **Candidate order** (nonzero-address valid requests only):
  - starving requesters first, in ascending index;
  - then the remaining requesters in round-robin order starting at `rr_ptr` (0..2).
- **Grant walk:** walk the candidate list and take up to two grants.
  - The first grant goes to port 1, the second to port 2.
  - A candidate whose address equals the address already granted to port 1 is skipped this cycle (stays not-ready). The walk continues to the next candidate.
- **Pointer update:** on any port-consuming grant, `rr_ptr` becomes (index of the last granted requester + 1) mod 3. With no port grant it is unchanged.
- **Wait counter** `wait_cnt[i]` (width covers `STARVE_LIMIT`):
  - increments, saturating at `STARVE_LIMIT`, when `req_valid[i] & ~req_ready[i]` and the address is nonzero;
  - clears otherwise.
  - `starve_flag[i]` = (`wait_cnt[i] == STARVE_LIMIT`).
- **Port registers:** on posedge, port 1 loads {1, addr, data} of its grant, or {0, 0, 0} if none; port 2 likewise.
- **Write ordering:** a request granted at cycle N lands in the register file at edge N+2. Writes to the same register from successive cycles therefore land in grant order.
- **Reset:**
  - forces `RegWrite`, `RegWrite2`, `Write_register*`, `Write_data*`, `rr_ptr`, `wait_cnt`, `starve_flag` to 0;
  - holds `req_ready` at 0 while `reset` is high.
  - A grant pending in the port registers when reset is asserted is dropped, not written.

## Timing
- **Handshake to port-enable:** 1 cycle. Handshake to register-file update: 2 posedges.
- **Throughput:** 2 nonzero writes per cycle, plus any number of x0 requests.
- **`req_ready` path:** purely combinational from `req_valid`, `req_addr`, `rr_ptr`, `wait_cnt`. There is no combinational path from `req_data` to any output.
- **Three valid, distinct nonzero addresses:** exactly two are granted; the third waits one cycle and is then first in round-robin order.
- **All three at the same address:** one grant per cycle, three cycles total, taken in candidate order.
- **`starve_flag` timing:** rises on the edge where the counter reaches the limit. It affects ordering in the following cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles with all `req_valid` = 3'b111 -> `req_ready` = 0 during reset; all port outputs and `starve_flag` = 0 on the first cycle after release.
- **Round-robin, distinct addresses:** `req_valid` = 3'b111, addrs 3/7/9, `rr_ptr` = 0 -> cycle 0 grants req0 (port 1, x3) and req1 (port 2, x7); cycle 1 grants req2 (port 1, x9); `rr_ptr` = 0 after cycle 1.
- **Same-address conflict:** req0 and req1 both target x5 with data 0xA/0xB, `rr_ptr` = 0 -> cycle 0 grants only req0; cycle 1 grants req1; x5 ends at 0xB.
- **x0 filter:** req1 targets x0 while req0 and req2 target x4 and x6 -> all three ready in the same cycle; ports write x4 and x6 only; `rr_ptr` unaffected by req1.
- **Starvation:** with `STARVE_LIMIT` = 2, keep req2 at x8 and repeatedly issue req0 and req1 both at x8 -> `starve_flag[2]` rises after 2 waiting cycles; on the next cycle req2 is granted on port 1 ahead of the round-robin order.
- **Reset mid-flight:** grant req0 to x10 at cycle N, assert `reset` at cycle N+1 -> `RegWrite` = 0 after the edge and x10 is not written.
